// File: rtl/regibank_mp.sv
// Multi-port integer register bank with tag-sequenced writes and a debug port.
// Build option: REGBANK_BYPASS_EN forwards same-cycle accepted writes to reads.
module regibank_mp #(
  parameter int XLEN       = 64,
  parameter int AW         = 6,
  parameter int TAG_WIDTH  = 3,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int DBG_STARVE = 4
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [RD_PORTS*AW-1:0]        i_radr,
  output logic [RD_PORTS*XLEN-1:0]      o_rdata,
  output logic [RD_PORTS*TAG_WIDTH-1:0] o_rtag,
  input  logic [WR_PORTS-1:0]           i_wena,
  input  logic [WR_PORTS*AW-1:0]        i_waddr,
  input  logic [WR_PORTS*TAG_WIDTH-1:0] i_wtag,
  input  logic [WR_PORTS*XLEN-1:0]      i_wdata,
  input  logic [WR_PORTS-1:0]           i_inorder,
  output logic [WR_PORTS-1:0]           o_ignored,
  input  logic                          i_dport_req_valid,
  output logic                          o_dport_req_ready,
  input  logic                          i_dport_write,
  input  logic [AW-1:0]                 i_dport_addr,
  input  logic [XLEN-1:0]               i_dport_wdata,
  output logic                          o_dport_resp_valid,
  input  logic                          i_dport_resp_ready,
  output logic [XLEN-1:0]               o_dport_rdata
);

  localparam int REGS = 2**AW;
  localparam int CW   = $clog2(DBG_STARVE + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [XLEN-1:0]      val_q [REGS];
  logic [TAG_WIDTH-1:0] tag_q [REGS];

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dwr_q, dwr_d;
  logic [AW-1:0]   daddr_q, daddr_d;
  logic [XLEN-1:0] dwdata_q, dwdata_d;
  logic [XLEN-1:0] drdata_q, drdata_d;

  logic [AW-1:0]        wa [WR_PORTS];
  logic [TAG_WIDTH-1:0] wt [WR_PORTS];
  logic [XLEN-1:0]      wd [WR_PORTS];

  logic [WR_PORTS-1:0] acc;
  logic [WR_PORTS-1:0] ign;
  logic                force_dbg;
  logic                dbg_perf;

  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) begin
      wa[w] = i_waddr[w*AW +: AW];
      wt[w] = i_wtag[w*TAG_WIDTH +: TAG_WIDTH];
      wd[w] = i_wdata[w*XLEN +: XLEN];
    end
  end

  assign force_dbg = (state_q == ST_ACCESS) && dwr_q
                   && (cnt_q == CW'(DBG_STARVE));

  // Only the highest-index enabled port per address is evaluated.
  always_comb begin
    acc = '0;
    ign = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      logic en, coll, tagok, floss;
      en    = i_wena[w] && (wa[w] != '0);
      coll  = 1'b0;
      for (int v = 0; v < WR_PORTS; v++) begin
        if (v > w && i_wena[v] && wa[v] == wa[w])
          coll = 1'b1;
      end
      tagok = !i_inorder[w]
            || (wt[w] == TAG_WIDTH'(tag_q[wa[w]] + 1'b1));
      floss = force_dbg && (wa[w] == daddr_q);
      acc[w] = en && !coll && tagok && !floss;
      ign[w] = en && (coll || !tagok || floss);
    end
  end

  assign o_ignored = ign;

  assign dbg_perf = (state_q == ST_ACCESS) && dwr_q
                  && (force_dbg || acc == '0);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int r = 0; r < REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      if (dbg_perf && daddr_q != '0)
        val_q[daddr_q] <= dwdata_q;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (acc[w]) begin
          val_q[wa[w]] <= wd[w];
          tag_q[wa[w]] <= wt[w];
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    o_rtag  = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      logic [AW-1:0]        a;
      logic [XLEN-1:0]      rd;
      logic [TAG_WIDTH-1:0] rt;
      a  = i_radr[p*AW +: AW];
      rd = val_q[a];
      rt = tag_q[a];
`ifdef REGBANK_BYPASS_EN
      if (dbg_perf && daddr_q == a)
        rd = dwdata_q;
      for (int w = 0; w < WR_PORTS; w++) begin
        if (acc[w] && wa[w] == a) begin
          rd = wd[w];
          rt = wt[w];
        end
      end
`endif
      if (a == '0) begin
        rd = '0;
        rt = '0;
      end
      o_rdata[p*XLEN +: XLEN]          = rd;
      o_rtag[p*TAG_WIDTH +: TAG_WIDTH] = rt;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwr_d    = dwr_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dport_req_valid) begin
          dwr_d    = i_dport_write;
          daddr_d  = i_dport_addr;
          dwdata_d = i_dport_wdata;
          cnt_d    = '0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!dwr_q) begin
          drdata_d = val_q[daddr_q];
          state_d  = ST_RESP;
        end else if (dbg_perf) begin
          drdata_d = '0;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (i_dport_resp_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dwr_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwr_q    <= dwr_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign o_dport_req_ready  = (state_q == ST_IDLE);
  assign o_dport_resp_valid = (state_q == ST_RESP);
  assign o_dport_rdata      = drdata_q;

endmodule

// File: tb/tb_regibank_mp.sv
// Directed bench for regibank_mp: table-driven core writes plus
// hand-written debug-port sequences (starvation, held response, reset).
module tb_regibank_mp;

  logic         clk;
  logic         nrst;
  logic [11:0]  radr;
  logic [127:0] rdata;
  logic [5:0]   rtag;
  logic [1:0]   wena;
  logic [11:0]  waddr;
  logic [5:0]   wtag;
  logic [127:0] wdata;
  logic [1:0]   inorder;
  logic [1:0]   ignored;
  logic         req_valid;
  logic         req_ready;
  logic         dwrite;
  logic [5:0]   daddr;
  logic [63:0]  dwdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  drdata;

  int errors = 0;
  int checks = 0;

  regibank_mp dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_radr(radr), .o_rdata(rdata), .o_rtag(rtag),
    .i_wena(wena), .i_waddr(waddr), .i_wtag(wtag),
    .i_wdata(wdata), .i_inorder(inorder), .o_ignored(ignored),
    .i_dport_req_valid(req_valid), .o_dport_req_ready(req_ready),
    .i_dport_write(dwrite), .i_dport_addr(daddr),
    .i_dport_wdata(dwdata), .o_dport_resp_valid(resp_valid),
    .i_dport_resp_ready(resp_ready), .o_dport_rdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wena;
    logic [5:0]  wa0, wa1;
    logic [2:0]  wt0, wt1;
    logic [63:0] wd0, wd1;
    logic [1:0]  inord;
    logic [1:0]  exp_ign;
    logic [5:0]  radr;
    logic [63:0] exp_data;
    logic [2:0]  exp_tag;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(
    logic [1:0] we, logic [5:0] a0, logic [2:0] t0, logic [63:0] d0,
    logic [5:0] a1, logic [2:0] t1, logic [63:0] d1, logic [1:0] io,
    logic [1:0] ei, logic [5:0] ra, logic [63:0] ed, logic [2:0] et);
    vec_t v;
    v.wena = we; v.wa0 = a0; v.wt0 = t0; v.wd0 = d0;
    v.wa1 = a1; v.wt1 = t1; v.wd1 = d1; v.inord = io;
    v.exp_ign = ei; v.radr = ra; v.exp_data = ed; v.exp_tag = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_core();
    wena = '0; waddr = '0; wtag = '0; wdata = '0; inorder = '0;
  endtask

  task automatic rd_both(input logic [5:0] a);
    radr = {a, a};
  endtask

  task automatic dbg_txn(input logic wr, input logic [5:0] a,
                         input logic [63:0] d, input logic [63:0] exp_rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; dwrite = wr; daddr = a; dwdata = d;
    #1 chk("dbg_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dbg_resp_seen", 64'(resp_valid), 64'd1);
    chk("dbg_rdata", drdata, exp_rd);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1 chk("dbg_back_idle", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int forced_at;
    nrst = 1'b0;
    radr = '0;
    idle_core();
    req_valid = 1'b0; dwrite = 1'b0; daddr = '0; dwdata = '0;
    resp_ready = 1'b0;

    vecs[0] = mk(2'b01, 6'd5, 3'd1, 64'hA5, 6'd0, 3'd0, 64'h0,
                 2'b01, 2'b00, 6'd5, 64'hA5, 3'd1);
    vecs[1] = mk(2'b01, 6'd5, 3'd3, 64'hBB, 6'd0, 3'd0, 64'h0,
                 2'b01, 2'b01, 6'd5, 64'hA5, 3'd1);
    vecs[2] = mk(2'b11, 6'd7, 3'd0, 64'h11, 6'd7, 3'd2, 64'h22,
                 2'b00, 2'b01, 6'd7, 64'h22, 3'd2);
    vecs[3] = mk(2'b01, 6'd0, 3'd1, 64'hFF, 6'd0, 3'd0, 64'h0,
                 2'b00, 2'b00, 6'd0, 64'h0, 3'd0);
    vecs[4] = mk(2'b10, 6'd0, 3'd0, 64'h0, 6'd4, 3'd1, 64'hC4,
                 2'b10, 2'b00, 6'd4, 64'hC4, 3'd1);
    vecs[5] = mk(2'b11, 6'd6, 3'd7, 64'h66, 6'd8, 3'd4, 64'h88,
                 2'b10, 2'b10, 6'd6, 64'h66, 3'd7);
    vecs[6] = mk(2'b01, 6'd6, 3'd0, 64'h60, 6'd0, 3'd0, 64'h0,
                 2'b01, 2'b00, 6'd6, 64'h60, 3'd0);
    vecs[7] = mk(2'b11, 6'd4, 3'd3, 64'h1, 6'd4, 3'd3, 64'h2,
                 2'b10, 2'b11, 6'd4, 64'hC4, 3'd1);

    rd_both(6'd5);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata0", rdata[63:0], 64'h0);
    chk("rst_rdata1", rdata[127:64], 64'h0);
    chk("rst_rtag", 64'(rtag), 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_dport_rdata", drdata, 64'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wena = vecs[i].wena;
      waddr = {vecs[i].wa1, vecs[i].wa0};
      wtag = {vecs[i].wt1, vecs[i].wt0};
      wdata = {vecs[i].wd1, vecs[i].wd0};
      inorder = vecs[i].inord;
      #1 chk($sformatf("v%0d_ignored", i), 64'(ignored),
             64'(vecs[i].exp_ign));
      @(negedge clk);
      idle_core();
      rd_both(vecs[i].radr);
      #1;
      chk($sformatf("v%0d_rdata0", i), rdata[63:0], vecs[i].exp_data);
      chk($sformatf("v%0d_rdata1", i), rdata[127:64], vecs[i].exp_data);
      chk($sformatf("v%0d_rtag", i), 64'(rtag[2:0]), 64'(vecs[i].exp_tag));
    end

    // debug write starved by a core write to x9 every cycle
    forced_at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = (k == 0);
      dwrite = 1'b1; daddr = 6'd9; dwdata = 64'hDEAD;
      wena = 2'b01; waddr = {6'd0, 6'd9};
      wtag = {3'd0, 3'(k)}; wdata = {64'h0, 64'h100 + 64'(k)};
      #1;
      if (ignored[0]) begin
        forced_at = k;
        break;
      end
    end
    chk("starve_force_cycle", 64'(forced_at), 64'd5);
    @(negedge clk);
    idle_core();
    rd_both(6'd9);
    #1;
    chk("starve_resp_valid", 64'(resp_valid), 64'd1);
    chk("starve_dport_rdata", drdata, 64'h0);
    chk("starve_x9_val", rdata[63:0], 64'hDEAD);
    chk("starve_x9_tag", 64'(rtag[2:0]), 64'd4);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    dbg_txn(1'b1, 6'd10, 64'h1234, 64'h0);
    rd_both(6'd10);
    #1 chk("dbgwr_x10", rdata[63:0], 64'h1234);
    chk("dbgwr_x10_tag", 64'(rtag[2:0]), 64'd0);
    dbg_txn(1'b1, 6'd0, 64'hFFFF, 64'h0);
    rd_both(6'd0);
    #1 chk("dbgwr_x0", rdata[63:0], 64'h0);
    dbg_txn(1'b0, 6'd7, 64'h0, 64'h22);

    // debug read held with resp_ready low, then reset in RESP
    @(negedge clk);
    req_valid = 1'b1; dwrite = 1'b0; daddr = 6'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_valid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("hold%0d_rdata", c), drdata, 64'hA5);
      @(negedge clk);
    end
    #1 nrst = 1'b0;
    #1;
    chk("rst_resp_abort", 64'(resp_valid), 64'd0);
    chk("rst_abort_rdata", drdata, 64'h0);
    rd_both(6'd5);
    #1 chk("rst_array_clear", rdata[63:0], 64'h0);
    @(negedge clk);
    nrst = 1'b1;

    // same-cycle read of a write
    @(negedge clk);
    wena = 2'b10; waddr = {6'd3, 6'd0};
    wtag = {3'd1, 3'd0}; wdata = {64'h33, 64'h0};
    rd_both(6'd3);
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_same", rdata[63:0], 64'h33);
    chk("bypass_tag", 64'(rtag[2:0]), 64'd1);
`else
    chk("nobypass_same", rdata[63:0], 64'h0);
    chk("nobypass_tag", 64'(rtag[2:0]), 64'd0);
`endif
    @(negedge clk);
    idle_core();
    #1 chk("bypass_next", rdata[63:0], 64'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
